// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter (double dabble) feeding a two-digit multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens digit while it is zero.
module count_bcd_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] count_in,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       bcd_valid,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned BIN_W  = 7;
  localparam int unsigned SR_W   = 15;
  localparam int unsigned ITER_W = 3;
  localparam int unsigned SCAN_W = 8;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BIN_W-1:0]  MAX_VAL   = 7'd99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [SR_W-1:0]   sr, sr_nx;
  logic [ITER_W-1:0] iter, iter_nx;
  logic              load_c;
  logic [BIN_W-1:0]  cap_c;
  logic [SCAN_W-1:0] scan, scan_nx;
  logic [1:0]        an_nx;
  logic [6:0]        seg_nx;
  logic [3:0]        digit_c;
  logic              blank_c;

  // Shift register layout: {tens[14:11], ones[10:7], binary[6:0]}
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    return {t[SR_W-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign cap_c = (count_in > MAX_VAL) ? MAX_VAL : count_in;

  // Conversion FSM: capture, seven dabble steps, load
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    iter_nx  = iter;
    load_c   = 1'b0;
    case (state)
      IDLE: begin
        sr_nx    = {8'd0, cap_c};
        iter_nx  = '0;
        state_nx = SHIFT;
      end
      SHIFT: begin
        sr_nx   = dabble(sr);
        iter_nx = iter + ITER_W'(1);
        if (iter == LAST_ITER) state_nx = DONE;
      end
      DONE: begin
        load_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_c = an_nx[1] && (bcd_tens == 4'd0);
`else
  assign blank_c = 1'b0;
`endif

  // Display scan: seg always encodes the digit the upcoming an value selects
  always_comb begin
    scan_nx = scan + SCAN_W'(1);
    an_nx   = an;
    seg_nx  = seg;
    digit_c = an[0] ? bcd_tens : bcd_ones;
    if (scan == SCAN_LAST) begin
      scan_nx = '0;
      an_nx   = {an[0], an[1]};
      seg_nx  = blank_c ? 7'h00 : seg_enc(digit_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      iter      <= '0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      bcd_valid <= 1'b0;
      scan      <= '0;
      an        <= 2'b01;
      seg       <= 7'h3F;
    end else begin
      state     <= state_nx;
      sr        <= sr_nx;
      iter      <= iter_nx;
      bcd_valid <= load_c;
      if (load_c) begin
        bcd_tens <= sr[14:11];
        bcd_ones <= sr[10:7];
      end
      scan <= scan_nx;
      an   <= an_nx;
      seg  <= seg_nx;
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// Self-checking bench for count_bcd_display: directed scenarios plus random count_in,
// compared every cycle against an arithmetic model of the conversion and display timing.
module tb_count_bcd_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned PERIOD   = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] count_in = 7'd0;
  logic [3:0] bcd_tens, bcd_ones;
  logic       bcd_valid;
  logic [6:0] seg;
  logic [1:0] an;

  int checks   = 0;
  int failures = 0;

  // Model state: t = edges with rst high since the last reset edge
  int         t = 0;
  int         held = 0;
  int         m_tens = 0, m_ones = 0;
  logic       m_valid = 1'b0;
  logic [1:0] m_an = 2'b01;
  logic [6:0] m_seg = 7'h3F;

  count_bcd_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .bcd_valid(bcd_valid),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return tbl[d];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [6:0] c);
    int old_t, old_o;
    if (!r) begin
      t = 0; m_tens = 0; m_ones = 0; m_valid = 1'b0; m_an = 2'b01; m_seg = 7'h3F;
    end else begin
      old_t = m_tens;
      old_o = m_ones;
      m_valid = 1'b0;
      if ((t % SCAN_DIV) == SCAN_DIV - 1) begin
        m_an = (m_an == 2'b01) ? 2'b10 : 2'b01;
        if (m_an == 2'b10) begin
`ifdef LEADING_ZERO_BLANK_EN
          m_seg = (old_t == 0) ? 7'h00 : enc(old_t);
`else
          m_seg = enc(old_t);
`endif
        end else begin
          m_seg = enc(old_o);
        end
      end
      if ((t % PERIOD) == 0) held = (int'(c) > 99) ? 99 : int'(c);
      if ((t % PERIOD) == PERIOD - 1) begin
        m_tens  = held / 10;
        m_ones  = held % 10;
        m_valid = 1'b1;
      end
      t++;
    end
  endtask

  task automatic cyc(input logic r, input logic [6:0] c);
    rst = r;
    count_in = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    chk("bcd_tens",  16'(bcd_tens),  16'(m_tens));
    chk("bcd_ones",  16'(bcd_ones),  16'(m_ones));
    chk("bcd_valid", 16'(bcd_valid), 16'(m_valid));
    chk("an",        16'(an),        16'(m_an));
    chk("seg",       16'(seg),       16'(m_seg));
  endtask

  initial begin
    // Reset for two cycles
    cyc(1'b0, 7'd0);
    cyc(1'b0, 7'd0);
    chk("reset_seg", 16'(seg), 16'h3F);

    // Basic conversion of 57
    repeat (18) cyc(1'b1, 7'd57);
    chk("conv57_tens", 16'(bcd_tens), 16'd5);
    chk("conv57_ones", 16'(bcd_ones), 16'd7);

    // Upstream wrap 98 -> 99 -> 0
    cyc(1'b0, 7'd0);
    repeat (9) cyc(1'b1, 7'd98);
    chk("wrap98", 16'({bcd_tens, bcd_ones}), 16'h98);
    repeat (9) cyc(1'b1, 7'd99);
    chk("wrap99", 16'({bcd_tens, bcd_ones}), 16'h99);
    repeat (9) cyc(1'b1, 7'd0);
    chk("wrap00", 16'({bcd_tens, bcd_ones}), 16'h00);
    repeat (9) cyc(1'b1, 7'd0);

    // Clamp of out-of-range input
    cyc(1'b0, 7'd0);
    repeat (9) cyc(1'b1, 7'd120);
    chk("clamp", 16'({bcd_tens, bcd_ones}), 16'h99);

    // Reset during the third shift cycle abandons the conversion
    cyc(1'b0, 7'd0);
    repeat (3) cyc(1'b1, 7'd42);
    cyc(1'b0, 7'd42);
    repeat (8) cyc(1'b1, 7'd42);
    chk("abort_hold", 16'({bcd_tens, bcd_ones}), 16'h00);
    cyc(1'b1, 7'd42);
    chk("abort_conv", 16'({bcd_tens, bcd_ones}), 16'h42);

    // Leading zero on tens digit
    cyc(1'b0, 7'd0);
    repeat (20) cyc(1'b1, 7'd7);

    // Random count_in every cycle with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) cyc(1'b0, 7'($urandom_range(0, 127)));
      else cyc(1'b1, 7'($urandom_range(0, 127)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_bcd_display.md
COUNT_BCD_DISPLAY -- requirements
Module: count_bcd_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, giving the clock cycles each display digit stays enabled; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port count_in, input, 7 bits, binary count from the upstream mod-100 counter.
REQ-005 SHALL have port bcd_tens, output, 4 bits, registered tens digit.
REQ-006 SHALL have port bcd_ones, output, 4 bits, registered ones digit.
REQ-007 SHALL have port bcd_valid, output, 1 bit, one-cycle pulse when new digits are loaded.
REQ-008 SHALL have port seg, output, 7 bits, active-high segments with seg[0]=a through seg[6]=g.
REQ-009 SHALL have port an, output, 2 bits, one-hot active-high digit enable: 2'b01 selects ones, 2'b10 selects tens.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and DONE, with no other reachable state.
REQ-011 In IDLE, every edge SHALL capture count_in into the shift register, clear the 3-bit iteration counter and go to SHIFT.
REQ-012 count_in values 100..127 SHALL be clamped to 99 at capture.
REQ-013 SHIFT SHALL perform one double-dabble step per cycle (add 3 to any BCD nibble >=5, then shift left 1) for exactly 7 cycles, then go to DONE.
REQ-014 DONE SHALL load bcd_tens/bcd_ones, assert bcd_valid for exactly that cycle and return to IDLE.
REQ-015 A value sampled at edge N SHALL appear on bcd_tens/bcd_ones and bcd_valid after edge N+8; the conversion period SHALL be 9 cycles.
REQ-016 Changes on count_in outside the IDLE capture edge SHALL be ignored until the next capture.
REQ-017 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on each wrap an SHALL toggle between 2'b01 and 2'b10.
REQ-018 seg SHALL be registered and updated on the same edge as an, encoding the digit selected by the next an value.
REQ-019 Segment encoding SHALL be 0:7'h3F 1:7'h06 2:7'h5B 3:7'h4F 4:7'h66 5:7'h6D 6:7'h7D 7:7'h07 8:7'h7F 9:7'h6F.
REQ-020 bcd_tens/bcd_ones SHALL never hold a value above 9.
REQ-021 The bcd_valid pulse SHALL NOT disturb the scan sequence; new digits SHALL take effect on the next seg update.

Reset
REQ-022 With rst low at an edge, state SHALL become IDLE, the scan counter 0, bcd_tens=0, bcd_ones=0, bcd_valid=0, an=2'b01 and seg=7'h3F.
REQ-023 Reset asserted mid-SHIFT SHALL abandon the conversion, with no bcd_valid pulse and no partial digits loaded.
REQ-024 The first capture SHALL occur on the first edge with rst high.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN SHALL control tens-digit blanking.
- Defined: while an=2'b10 and bcd_tens=0, seg SHALL be 7'h00.
- Undefined: the tens digit 0 SHALL display as 7'h3F.
- Either way: bcd outputs and ones-digit display are unaffected.

Verification
REQ-026 Reset check: rst low 2 cycles, count_in=0 -> bcd_tens=0, bcd_ones=0, bcd_valid=0, an=2'b01, seg=7'h3F.
REQ-027 Basic conversion: count_in=57 held after reset release -> bcd_valid pulse 8 cycles after the capture edge; tens=5, ones=7; seg=7'h6D when an=2'b10, seg=7'h07 when an=2'b01, an toggling every 4 cycles.
REQ-028 Upstream wrap: count_in steps 98, 99, 0 with each held 9 cycles -> successive bcd results 9/8, 9/9, 0/0.
REQ-029 Clamp: count_in=120 -> bcd_tens=9, bcd_ones=9.
REQ-030 Reset mid-conversion: count_in=42, rst low at the 3rd SHIFT cycle -> no bcd_valid pulse, bcd stays 0/0, and 4/2 appears 8 cycles after the first post-reset capture.
REQ-031 Blanking: count_in=7 -> with LEADING_ZERO_BLANK_EN, seg=7'h00 when an=2'b10; without it, seg=7'h3F; in both builds seg=7'h07 when an=2'b01.
